// File: rtl/regs_dump_if.sv
// ---------------------------------------------------------------------------
// regs_dump_if
// Bundles the register-file write port, the two read ports, the two
// observation taps and the debug dump stream into one interface.
//   Parameters : N (data width), A (address width)
//   master     : the datapath/debug side. It drives we/waddr/wdata,
//                raddr1/raddr2, dump_start and dump_ready.
//   slave      : the register file. It drives rdata1/rdata2, tap0/tap1,
//                dump_busy, dump_valid, dump_addr, dump_data and dump_last.
// ---------------------------------------------------------------------------
interface regs_dump_if #(
    parameter int N = 8,
    parameter int A = 3
);
    // write port
    logic                we;
    logic [A-1:0]        waddr;
    logic [N-1:0]        wdata;
    // read ports and taps
    logic [A-1:0]        raddr1;
    logic [A-1:0]        raddr2;
    logic signed [N-1:0] rdata1;
    logic signed [N-1:0] rdata2;
    logic signed [N-1:0] tap0;
    logic signed [N-1:0] tap1;
    // dump stream
    logic                dump_start;
    logic                dump_busy;
    logic                dump_valid;
    logic                dump_ready;
    logic [A-1:0]        dump_addr;
    logic [N-1:0]        dump_data;
    logic                dump_last;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, dump_start, dump_ready,
        input  rdata1, rdata2, tap0, tap1,
               dump_busy, dump_valid, dump_addr, dump_data, dump_last
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, dump_start, dump_ready,
        output rdata1, rdata2, tap0, tap1,
               dump_busy, dump_valid, dump_addr, dump_data, dump_last
    );
endinterface

// File: rtl/regs_dump.sv
// ---------------------------------------------------------------------------
// regs_dump
// This is a parametrised picoMIPS register file. It has 2**A entries of N
// bits, and entry 0 is hard-wired to zero. It provides one write port and two
// combinational read ports. Two fixed taps show registers TAP0 and TAP1.
// A debug dump port streams registers 1..2**A-1 out over valid/ready. Each
// word is a snapshot of the register, taken on the edge that captures it.
//
// Ports:
//   clk    : single clock; all state changes on its rising edge
//   reset  : synchronous, active-high; clears every register and the dump FSM
//   bus    : regs_dump_if.slave (the write, read, tap and dump signals)
//
// Build option:
//   REGS_BYPASS_EN : when this is defined, a write in progress (we=1,
//                    waddr!=0) is forwarded in the same cycle. It reaches
//                    reads, taps and a dump capture at the same index. When
//                    it is undefined, these see the old value until the next
//                    cycle.
// ---------------------------------------------------------------------------
module regs_dump #(
    parameter int N    = 8,
    parameter int A    = 3,
    parameter int TAP0 = 3,
    parameter int TAP1 = 5
) (
    input  logic        clk,
    input  logic        reset,
    regs_dump_if.slave  bus
);

    localparam int           DEPTH    = 1 << A;
    localparam logic [A-1:0] FIRST    = A'(1);
    localparam logic [A-1:0] LAST     = A'(DEPTH - 1);
    localparam logic [A-1:0] TAP0_IDX = A'(TAP0);
    localparam logic [A-1:0] TAP1_IDX = A'(TAP1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic signed [N-1:0] regs [DEPTH];

    state_t              state_q, state_d;
    logic [A-1:0]        addr_q,  addr_d;
    logic signed [N-1:0] data_q,  data_d;

    // This function is the single read path. The read ports, the taps and
    // the dump capture all use it, so every reader sees the same forwarding
    // behaviour.
    function automatic logic signed [N-1:0] read_reg(input logic [A-1:0] addr);
        logic signed [N-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else begin
            val = regs[addr];
`ifdef REGS_BYPASS_EN
            if (bus.we && (bus.waddr == addr))
                val = bus.wdata;
`endif
        end
        return val;
    endfunction

    // Register array. Entry 0 is never written, so it keeps its reset value
    // of 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (bus.we && (bus.waddr != '0)) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    assign bus.rdata1 = read_reg(bus.raddr1);
    assign bus.rdata2 = read_reg(bus.raddr2);
    assign bus.tap0   = read_reg(TAP0_IDX);
    assign bus.tap1   = read_reg(TAP1_IDX);

    // Dump FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Dump FSM next state. In IDLE, addr/data are returned to 0, so the
    // dump outputs read 0 whenever no dump is in progress.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.dump_start) begin
                    state_d = SEND;
                    addr_d  = FIRST;
                    data_d  = read_reg(FIRST);
                end
            end
            SEND: begin
                if (bus.dump_ready) begin
                    if (addr_q == LAST) begin
                        state_d = IDLE;
                        addr_d  = '0;
                        data_d  = '0;
                    end else begin
                        addr_d  = addr_q + FIRST;
                        data_d  = read_reg(addr_q + FIRST);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                data_d  = '0;
            end
        endcase
    end

    assign bus.dump_busy  = (state_q == SEND);
    assign bus.dump_valid = (state_q == SEND);
    assign bus.dump_addr  = addr_q;
    assign bus.dump_data  = data_q;
    assign bus.dump_last  = (state_q == SEND) && (addr_q == LAST);

endmodule

// File: tb/tb_regs_dump.sv
// ---------------------------------------------------------------------------
// tb_regs_dump
// Directed testbench for regs_dump with N=8, A=3, TAP0=3, TAP1=5.
// Inputs change 1 time unit after each rising edge. Outputs are sampled
// there too, after the combinational paths have settled.
// ---------------------------------------------------------------------------
module tb_regs_dump;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    regs_dump_if #(.N(8), .A(3)) bus ();

    regs_dump #(.N(8), .A(3), .TAP0(3), .TAP1(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.raddr1 = '0; bus.raddr2 = '0;
        bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.raddr1 = 3'(a); bus.raddr2 = 3'(7 - a);
            #1;
            n_cmp++;
            if (bus.rdata1 !== 8'h00 || bus.rdata2 !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_read a=%0d: got %h/%h want 00/00", a, bus.rdata1, bus.rdata2);
            end
        end
        n_cmp++;
        if (bus.tap0 !== 8'h00 || bus.tap1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_taps: got %h/%h want 00/00", bus.tap0, bus.tap1);
        end
        n_cmp++;
        if ({bus.dump_busy, bus.dump_valid, bus.dump_last, bus.dump_addr, bus.dump_data} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_dump: got busy=%b valid=%b last=%b addr=%0d data=%h want all 0",
                     bus.dump_busy, bus.dump_valid, bus.dump_last, bus.dump_addr, bus.dump_data);
        end
    endtask

    task automatic test_write_read;
        write_reg(3'd3, 8'h5A);
        write_reg(3'd5, 8'hA5);
        write_reg(3'd0, 8'hFF);
        bus.raddr1 = 3'd3; bus.raddr2 = 3'd5;
        #1;
        n_cmp++;
        if (bus.rdata1 !== 8'h5A) begin
            n_fail++; $display("FAIL read_r3: got %h want 5a", bus.rdata1);
        end
        n_cmp++;
        if (bus.rdata2 !== 8'hA5) begin
            n_fail++; $display("FAIL read_r5: got %h want a5", bus.rdata2);
        end
        n_cmp++;
        if (bus.tap0 !== 8'h5A) begin
            n_fail++; $display("FAIL tap0: got %h want 5a", bus.tap0);
        end
        n_cmp++;
        if (bus.tap1 !== -8'sd91) begin
            n_fail++; $display("FAIL tap1_signed: got %0d want -91", bus.tap1);
        end
        bus.raddr1 = 3'd0;
        #1;
        n_cmp++;
        if (bus.rdata1 !== 8'h00) begin
            n_fail++; $display("FAIL read_r0: got %h want 00", bus.rdata1);
        end
    endtask

    task automatic test_bypass;
        logic [7:0] exp_same;
`ifdef REGS_BYPASS_EN
        exp_same = 8'h33;
`else
        exp_same = 8'h00;
`endif
        bus.raddr1 = 3'd2;
        bus.we = 1'b1; bus.waddr = 3'd2; bus.wdata = 8'h33;
        #1;
        n_cmp++;
        if (bus.rdata1 !== exp_same) begin
            n_fail++; $display("FAIL same_cycle_read: got %h want %h", bus.rdata1, exp_same);
        end
        tick();
        bus.we = 1'b0;
        #1;
        n_cmp++;
        if (bus.rdata1 !== 8'h33) begin
            n_fail++; $display("FAIL next_cycle_read: got %h want 33", bus.rdata1);
        end
    endtask

    task automatic test_dump_full;
        for (int r = 1; r < 8; r++) write_reg(3'(r), 8'(r));
        n_cmp++;
        if (bus.dump_busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_before_dump: got %b want 0", bus.dump_busy);
        end
        bus.dump_start = 1'b1; bus.dump_ready = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            n_cmp++;
            if (bus.dump_valid !== 1'b1 || bus.dump_busy !== 1'b1 || bus.dump_addr !== 3'(i) ||
                bus.dump_data !== 8'(i) || bus.dump_last !== (i == 7)) begin
                n_fail++;
                $display("FAIL dump_word%0d: got v=%b b=%b addr=%0d data=%h last=%b want v=1 b=1 addr=%0d data=%h last=%b",
                         i, bus.dump_valid, bus.dump_busy, bus.dump_addr, bus.dump_data, bus.dump_last,
                         i, 8'(i), (i == 7));
            end
            tick();
        end
        n_cmp++;
        if (bus.dump_busy !== 1'b0 || bus.dump_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dump_end: got busy=%b valid=%b want 0/0", bus.dump_busy, bus.dump_valid);
        end
        bus.dump_ready = 1'b0;
    endtask

    task automatic test_dump_stall;
        int         idx;
        int         cyc;
        logic       stalled;
        logic       wrote;
        logic       accepted;
        logic [2:0] held_addr;
        logic [7:0] held_data;
        logic [7:0] exp_data;
        idx = 1; cyc = 0; stalled = 1'b0; wrote = 1'b0;
        held_addr = '0; held_data = '0;
        bus.dump_start = 1'b1; bus.dump_ready = 1'b0;
        tick();
        bus.dump_start = 1'b0;
        while (idx <= 7 && cyc < 60) begin
            exp_data = (idx == 6) ? 8'h77 : 8'(idx);
            n_cmp++;
            if (bus.dump_valid !== 1'b1 || bus.dump_addr !== 3'(idx) || bus.dump_data !== exp_data ||
                bus.dump_last !== (idx == 7)) begin
                n_fail++;
                $display("FAIL stall_word%0d: got v=%b addr=%0d data=%h last=%b want v=1 addr=%0d data=%h last=%b",
                         idx, bus.dump_valid, bus.dump_addr, bus.dump_data, bus.dump_last,
                         idx, exp_data, (idx == 7));
            end
            if (stalled) begin
                n_cmp++;
                if (bus.dump_addr !== held_addr || bus.dump_data !== held_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: got addr=%0d data=%h want addr=%0d data=%h",
                             bus.dump_addr, bus.dump_data, held_addr, held_data);
                end
            end
            bus.dump_ready = (cyc % 2) == 1;
            if (!wrote && bus.dump_addr == 3'd2) begin
                bus.we = 1'b1; bus.waddr = 3'd6; bus.wdata = 8'h77;
                wrote = 1'b1;
            end
            stalled   = !bus.dump_ready;
            accepted  = bus.dump_ready;
            held_addr = bus.dump_addr;
            held_data = bus.dump_data;
            tick();
            bus.we = 1'b0;
            if (accepted) idx++;
            cyc++;
        end
        n_cmp++;
        if (idx <= 7) begin
            n_fail++; $display("FAIL stall_timeout: got %0d words want 7", idx - 1);
        end
        n_cmp++;
        if (bus.dump_busy !== 1'b0) begin
            n_fail++; $display("FAIL stall_end_busy: got %b want 0", bus.dump_busy);
        end
        bus.dump_ready = 1'b0;
    endtask

    task automatic test_reset_mid_dump;
        int cyc;
        cyc = 0;
        bus.dump_start = 1'b1; bus.dump_ready = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        while (bus.dump_addr != 3'd4 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (bus.dump_addr !== 3'd4) begin
            n_fail++; $display("FAIL reach_addr4: got %0d want 4", bus.dump_addr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.dump_ready = 1'b0;
        n_cmp++;
        if ({bus.dump_busy, bus.dump_valid, bus.dump_last, bus.dump_addr, bus.dump_data} !== 14'h0) begin
            n_fail++;
            $display("FAIL abort_dump: got busy=%b valid=%b last=%b addr=%0d data=%h want all 0",
                     bus.dump_busy, bus.dump_valid, bus.dump_last, bus.dump_addr, bus.dump_data);
        end
        for (int a = 1; a < 8; a++) begin
            bus.raddr1 = 3'(a);
            #1;
            n_cmp++;
            if (bus.rdata1 !== 8'h00) begin
                n_fail++; $display("FAIL cleared_r%0d: got %h want 00", a, bus.rdata1);
            end
        end
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        n_cmp++;
        if (bus.dump_valid !== 1'b1 || bus.dump_addr !== 3'd1 || bus.dump_data !== 8'h00) begin
            n_fail++;
            $display("FAIL restart_dump: got v=%b addr=%0d data=%h want v=1 addr=1 data=00",
                     bus.dump_valid, bus.dump_addr, bus.dump_data);
        end
        bus.dump_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        bus.dump_ready = 1'b0;
        // reset and a write on the same edge: the register must stay 0
        reset = 1'b1;
        bus.we = 1'b1; bus.waddr = 3'd4; bus.wdata = 8'h44;
        tick();
        reset = 1'b0; bus.we = 1'b0;
        bus.raddr2 = 3'd4;
        #1;
        n_cmp++;
        if (bus.rdata2 !== 8'h00) begin
            n_fail++; $display("FAIL reset_vs_write: got %h want 00", bus.rdata2);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass();
        test_dump_full();
        test_dump_stall();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
